glyph_fetch_sequencer: RTL and testbench

- Command-driven sequencer that renders one character glyph from font flash into a destination pixel stream.
- Walks a destination box of cmd_w x cmd_h pixels and maps each pixel to a source texel with 8.8 fixed-point DDA steps.
- Forms the 22-bit flash word address, issues reads over a req/ack handshake and emits one on/off pixel per destination pixel.
- Sits between the GPU ALU pipe command stage and the flash read controller; a one-word cache suppresses repeat reads.

---
 rtl/gpu_font_pkg.sv | 47 ++++
 rtl/glyph_texel_addr.sv | 32 +++
 rtl/glyph_fetch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_glyph_fetch_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_font_pkg.sv
// Shared glyph-font constants, sequencer state encoding and the flash word address packing.
// Used by glyph_fetch_sequencer and glyph_texel_addr.
package gpu_font_pkg;

   localparam int CHAR_W       = 64;
   localparam int CHAR_H       = 128;
   localparam int WORD_BITS    = 16;
   localparam int FLASH_ADDR_W = 22;
   localparam int FONT_IDX_W   = 5;
   localparam int CHAR_IDX_W   = 8;

   localparam int ROW_W     = $clog2(CHAR_H);
   localparam int COL_W     = $clog2(CHAR_W);
   localparam int BIT_W     = $clog2(WORD_BITS);
   localparam int COLWORD_W = COL_W - BIT_W;

   // 8.8 step accumulators carry one extra integer bit so they can saturate instead of wrapping
   localparam int FRAC_W = 8;
   localparam int ACC_W  = 17;
   localparam int INT_W  = ACC_W - FRAC_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_FETCH,
      ST_EMIT
   } seq_state_t;

   function automatic logic [FLASH_ADDR_W-1:0] pack_word_addr(
      input logic [FONT_IDX_W-1:0] font,
      input logic [CHAR_IDX_W-1:0] glyph_char,
      input logic [ROW_W-1:0]      row,
      input logic [COLWORD_W-1:0]  col_word
   );
      return {font, glyph_char, row, col_word};
   endfunction

   function automatic logic [ACC_W-1:0] sat_add(
      input logic [ACC_W-1:0] acc,
      input logic [15:0]      step
   );
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {{(ACC_W-15){1'b0}}, step};
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/glyph_texel_addr.sv
// Combinational texel locator: clamps the fixed-point source position to the glyph
// and returns the flash word address plus the bit index inside that word.
module glyph_texel_addr
   import gpu_font_pkg::*;
(
   input  logic [ACC_W-1:0]        acc_x,
   input  logic [ACC_W-1:0]        acc_y,
   input  logic [FONT_IDX_W-1:0]   font,
   input  logic [CHAR_IDX_W-1:0]   glyph_char,
   output logic [FLASH_ADDR_W-1:0] word_addr,
   output logic [BIT_W-1:0]        bit_idx
);

   logic [INT_W-1:0] int_x;
   logic [INT_W-1:0] int_y;
   logic [COL_W-1:0] src_x;
   logic [ROW_W-1:0] src_y;
   logic             unused_frac_bits;

   // Only the integer part selects a texel; positions past the glyph edge stick to the last texel
   always_comb begin
      int_x = acc_x[ACC_W-1:FRAC_W];
      int_y = acc_y[ACC_W-1:FRAC_W];
      src_x = (int_x > INT_W'(CHAR_W-1)) ? COL_W'(CHAR_W-1) : int_x[COL_W-1:0];
      src_y = (int_y > INT_W'(CHAR_H-1)) ? ROW_W'(CHAR_H-1) : int_y[ROW_W-1:0];
      word_addr = pack_word_addr(font, glyph_char, src_y, src_x[COL_W-1:BIT_W]);
      bit_idx   = src_x[BIT_W-1:0];
   end

   assign unused_frac_bits = ^{acc_x[FRAC_W-1:0], acc_y[FRAC_W-1:0]};

endmodule

// File: rtl/glyph_fetch_sequencer.sv
// Renders one glyph from font flash into a destination pixel stream with DDA scaling
// and a one-word read cache. Optional macro GLYPH_TRANSPARENT_SKIP_EN drops off pixels.
module glyph_fetch_sequencer
   import gpu_font_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [FONT_IDX_W-1:0]   cmd_font,
   input  logic [CHAR_IDX_W-1:0]   cmd_char,
   input  logic [9:0]              cmd_w,
   input  logic [9:0]              cmd_h,
   input  logic [15:0]             cmd_x,
   input  logic [15:0]             cmd_y,
   input  logic [15:0]             cmd_step_x,
   input  logic [15:0]             cmd_step_y,
   output logic                    flash_req,
   output logic [FLASH_ADDR_W-1:0] flash_addr,
   input  logic                    flash_ack,
   input  logic [WORD_BITS-1:0]    flash_data,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [15:0]             pix_x,
   output logic [15:0]             pix_y,
   output logic                    pix_on,
   output logic                    pix_last,
   output logic                    busy
);

   localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(WORD_BITS-1);

   seq_state_t state;
   seq_state_t state_next;

   logic [FONT_IDX_W-1:0]   font_q;
   logic [CHAR_IDX_W-1:0]   char_q;
   logic [9:0]              w_q;
   logic [9:0]              h_q;
   logic [15:0]             x0_q;
   logic [15:0]             y0_q;
   logic [15:0]             step_x_q;
   logic [15:0]             step_y_q;
   logic [9:0]              x_q;
   logic [9:0]              y_q;
   logic [ACC_W-1:0]        acc_x_q;
   logic [ACC_W-1:0]        acc_y_q;
   logic                    cache_valid_q;
   logic [FLASH_ADDR_W-1:0] cache_tag_q;
   logic [WORD_BITS-1:0]    cache_data_q;

   logic [FLASH_ADDR_W-1:0] word_addr;
   logic [BIT_W-1:0]        bit_idx;
   logic                    accept;
   logic                    fetch_done;
   logic                    advance;
   logic                    row_end;
   logic                    is_last;
   logic                    emit_on;
   logic                    emit_show;

   glyph_texel_addr u_texel_addr (
      .acc_x      (acc_x_q),
      .acc_y      (acc_y_q),
      .font       (font_q),
      .glyph_char (char_q),
      .word_addr  (word_addr),
      .bit_idx    (bit_idx)
   );

   assign row_end = (x_q == w_q - 10'd1);
   assign is_last = row_end && (y_q == h_q - 10'd1);
   assign emit_on = cache_data_q[MSB_IDX - bit_idx];

`ifdef GLYPH_TRANSPARENT_SKIP_EN
   // Blank texels are walked silently; the final pixel always shows so pix_last is seen
   assign emit_show = emit_on | is_last;
`else
   assign emit_show = 1'b1;
`endif

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      fetch_done = 1'b0;
      advance    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               accept = 1'b1;
               if (cmd_w != 10'd0 && cmd_h != 10'd0) begin
                  state_next = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            state_next = (cache_valid_q && cache_tag_q == word_addr) ? ST_EMIT : ST_FETCH;
         end
         ST_FETCH: begin
            if (flash_ack) begin
               fetch_done = 1'b1;
               state_next = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (pix_ready || !emit_show) begin
               advance    = 1'b1;
               state_next = is_last ? ST_IDLE : ST_ADDR;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         font_q        <= '0;
         char_q        <= '0;
         w_q           <= '0;
         h_q           <= '0;
         x0_q          <= '0;
         y0_q          <= '0;
         step_x_q      <= '0;
         step_y_q      <= '0;
         x_q           <= '0;
         y_q           <= '0;
         acc_x_q       <= '0;
         acc_y_q       <= '0;
         cache_valid_q <= 1'b0;
         cache_tag_q   <= '0;
         cache_data_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            font_q        <= cmd_font;
            char_q        <= cmd_char;
            w_q           <= cmd_w;
            h_q           <= cmd_h;
            x0_q          <= cmd_x;
            y0_q          <= cmd_y;
            step_x_q      <= cmd_step_x;
            step_y_q      <= cmd_step_y;
            x_q           <= '0;
            y_q           <= '0;
            acc_x_q       <= '0;
            acc_y_q       <= '0;
            cache_valid_q <= 1'b0;
         end
         if (fetch_done) begin
            cache_data_q  <= flash_data;
            cache_tag_q   <= word_addr;
            cache_valid_q <= 1'b1;
         end
         if (advance && !is_last) begin
            if (row_end) begin
               x_q     <= '0;
               acc_x_q <= '0;
               y_q     <= y_q + 10'd1;
               acc_y_q <= sat_add(acc_y_q, step_y_q);
            end else begin
               x_q     <= x_q + 10'd1;
               acc_x_q <= sat_add(acc_x_q, step_x_q);
            end
         end
      end
   end

   // cmd_ready is gated by reset so every output reads 0 while reset_n is low
   assign cmd_ready  = reset_n && (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign flash_req  = (state == ST_FETCH);
   assign flash_addr = flash_req ? word_addr : '0;
   assign pix_valid  = (state == ST_EMIT) && emit_show;
   assign pix_x      = pix_valid ? x0_q + 16'(x_q) : 16'd0;
   assign pix_y      = pix_valid ? y0_q + 16'(y_q) : 16'd0;
   assign pix_on     = pix_valid && emit_on;
   assign pix_last   = pix_valid && is_last;

endmodule

// File: tb/tb_glyph_fetch_sequencer.sv
// Self-checking bench for glyph_fetch_sequencer: a flash responder, a pixel monitor and a
// raster-order reference model of the glyph walk, driven by directed and random commands.
module tb_glyph_fetch_sequencer;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_font;
   logic [7:0]  cmd_char;
   logic [9:0]  cmd_w;
   logic [9:0]  cmd_h;
   logic [15:0] cmd_x;
   logic [15:0] cmd_y;
   logic [15:0] cmd_step_x;
   logic [15:0] cmd_step_y;
   logic        flash_req;
   logic [21:0] flash_addr;
   logic        flash_ack;
   logic [15:0] flash_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_x;
   logic [15:0] pix_y;
   logic        pix_on;
   logic        pix_last;
   logic        busy;

   typedef struct {
      logic [15:0] px;
      logic [15:0] py;
      logic        on;
      logic        last;
      logic        miss;
   } pix_t;

   pix_t        exp_pix[$];
   logic [21:0] exp_addr[$];
   pix_t        head;
   logic [21:0] exp_first_addr;
   logic [21:0] held_addr;
   logic [21:0] got_addr;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int exp_reads;
   int reads_seen;
   int hs_count;
   int last_count;
   int last_hs_cycle;
   int fixed_lat = -1;
   int wait_left;
   int ready_mode = 0;
   int stall_left = 0;
   bit gap_check = 0;
   bit spurious_en = 0;
   bit pending = 0;
   bit hold_active = 0;

   glyph_fetch_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_font   (cmd_font),
      .cmd_char   (cmd_char),
      .cmd_w      (cmd_w),
      .cmd_h      (cmd_h),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .cmd_step_x (cmd_step_x),
      .cmd_step_y (cmd_step_y),
      .flash_req  (flash_req),
      .flash_addr (flash_addr),
      .flash_ack  (flash_ack),
      .flash_data (flash_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_on     (pix_on),
      .pix_last   (pix_last),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Deterministic font flash contents
   function automatic logic [15:0] flash_word(input logic [21:0] a);
      logic [31:0] t;
      t = {10'b0, a} * 32'h9E37_79B1;
      return t[31:16] ^ t[15:0];
   endfunction

   // Reference walk: every destination pixel in raster order, texel picked by clamped DDA position
   task automatic buildModel(input int font, input int chr, input int w, input int h,
                             input logic [15:0] x0, input logic [15:0] y0, input int sx, input int sy);
      int ax, ay, tx, ty, word, prev;
      bit have, on, last, show;
      logic [15:0] data;
      exp_pix.delete();
      exp_addr.delete();
      exp_reads = 0;
      reads_seen = 0;
      hs_count = 0;
      last_count = 0;
      last_hs_cycle = -1;
      have = 0;
      prev = 0;
      exp_first_addr = '0;
      for (int y = 0; y < h; y++) begin
         ay = y * sy;
         if (ay > 131071) ay = 131071;
         ty = ay / 256;
         if (ty > 127) ty = 127;
         for (int x = 0; x < w; x++) begin
            ax = x * sx;
            if (ax > 131071) ax = 131071;
            tx = ax / 256;
            if (tx > 63) tx = 63;
            word = font * 131072 + chr * 512 + ty * 4 + tx / 16;
            if (!have || word != prev) begin
               if (!have) exp_first_addr = 22'(word);
               exp_addr.push_back(22'(word));
               exp_reads++;
            end
            data = flash_word(22'(word));
            on = data[15 - (tx % 16)];
            last = (x == w - 1) && (y == h - 1);
`ifdef GLYPH_TRANSPARENT_SKIP_EN
            show = on || last;
`else
            show = 1'b1;
`endif
            if (show)
               exp_pix.push_back('{px: x0 + 16'(x), py: y0 + 16'(y), on: on, last: last,
                                   miss: (!have || word != prev)});
            have = 1;
            prev = word;
         end
      end
   endtask

   task automatic sendCmd(input int font, input int chr, input int w, input int h,
                          input logic [15:0] x0, input logic [15:0] y0, input int sx, input int sy);
      int guard = 0;
      @(posedge clk); #1;
      while (!cmd_ready && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_font   = 5'(font);
      cmd_char   = 8'(chr);
      cmd_w      = 10'(w);
      cmd_h      = 10'(h);
      cmd_x      = x0;
      cmd_y      = y0;
      cmd_step_x = 16'(sx);
      cmd_step_y = 16'(sy);
      cmd_valid  = 1'b1;
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
   endtask

   task automatic applyStimulus(input int font, input int chr, input int w, input int h,
                                input logic [15:0] x0, input logic [15:0] y0, input int sx, input int sy);
      int guard = 0;
      int req_seen = 0;
      int valid_seen = 0;
      int not_ready = 0;
      buildModel(font, chr, w, h, x0, y0, sx, sy);
      sendCmd(font, chr, w, h, x0, y0, sx, sy);
      if (w == 0 || h == 0) begin
         repeat (8) begin
            if (flash_req) req_seen++;
            if (pix_valid) valid_seen++;
            if (!cmd_ready) not_ready++;
            @(posedge clk); #1;
         end
         checkOutput("empty_req", req_seen, 0);
         checkOutput("empty_valid", valid_seen, 0);
         checkOutput("empty_not_ready", not_ready, 0);
      end else begin
         checkOutput("lat_c1_busy", busy, 1'b1);
         checkOutput("lat_c1_ready", cmd_ready, 1'b0);
         checkOutput("lat_c1_req", flash_req, 1'b0);
         @(posedge clk); #1;
         checkOutput("lat_c2_req", flash_req, 1'b1);
         got_addr = flash_addr;
         checkOutput("lat_c2_addr", got_addr, exp_first_addr);
         while ((exp_pix.size() != 0 || !cmd_ready) && guard < 60 * w * h + 400) begin
            @(negedge clk);
            guard++;
         end
         checkOutput("cmd_done", (exp_pix.size() == 0) && cmd_ready, 1'b1);
         checkOutput("flash_reads", reads_seen, exp_reads);
         checkOutput("addr_left", exp_addr.size(), 0);
      end
   endtask

   // Flash side: checks each read address, holds ack for one cycle after a chosen latency
   initial begin
      flash_ack  = 1'b0;
      flash_data = '0;
      forever begin
         @(negedge clk);
         flash_ack = 1'b0;
         if (!reset_n) begin
            pending = 0;
         end else if (flash_req) begin
            if (!pending) begin
               pending   = 1;
               held_addr = flash_addr;
               wait_left = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
               reads_seen++;
               if (exp_addr.size() == 0) checkOutput("extra_read", 1'b1, 1'b0);
               else checkOutput("read_addr", flash_addr, exp_addr.pop_front());
            end else begin
               checkOutput("addr_held", flash_addr, held_addr);
            end
            if (wait_left == 0) begin
               flash_ack  = 1'b1;
               flash_data = flash_word(held_addr);
               pending    = 0;
            end else begin
               wait_left--;
            end
         end else begin
            if (pending) begin
               checkOutput("req_dropped", 1'b0, 1'b1);
               pending = 0;
            end
            if (spurious_en && $urandom_range(0, 7) == 0) begin
               flash_ack  = 1'b1;
               flash_data = 16'($urandom);
            end
         end
      end
   end

   initial begin
      pix_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: pix_ready = 1'b1;
            1: pix_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (hs_count == 60 && stall_left > 0) begin
                  pix_ready = 1'b0;
                  stall_left--;
               end else begin
                  pix_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // Any offered pixel must equal the head of the expected stream, stalled or not
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            hold_active = 0;
         end else begin
            if (hold_active) checkOutput("hold_valid", pix_valid, 1'b1);
            hold_active = 0;
            if (pix_valid) begin
               if (exp_pix.size() == 0) begin
                  checkOutput("extra_pixel", 1'b1, 1'b0);
               end else begin
                  head = exp_pix[0];
                  checkOutput("pix_x", pix_x, head.px);
                  checkOutput("pix_y", pix_y, head.py);
                  checkOutput("pix_on", pix_on, head.on);
                  checkOutput("pix_last", pix_last, head.last);
                  if (pix_ready) begin
                      void'(exp_pix.pop_front());
`ifndef GLYPH_TRANSPARENT_SKIP_EN
                     if (gap_check && last_hs_cycle >= 0)
                        checkOutput("pix_gap", cycle - last_hs_cycle, head.miss ? 3 + fixed_lat : 2);
`endif
                  end
               end
               if (pix_ready) begin
                  hs_count++;
                  if (pix_last) last_count++;
                  last_hs_cycle = cycle;
               end else begin
                  hold_active = 1;
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int w, h;
      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_font   = '0;
      cmd_char   = '0;
      cmd_w      = '0;
      cmd_h      = '0;
      cmd_x      = '0;
      cmd_y      = '0;
      cmd_step_x = '0;
      cmd_step_y = '0;
      #13;
      checkOutput("rst_ready", cmd_ready, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_req", flash_req, 1'b0);
      checkOutput("rst_valid", pix_valid, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", cmd_ready, 1'b1);

      $display("[TB] full glyph at unit scale");
      fixed_lat = 3; ready_mode = 0; gap_check = 1;
      applyStimulus(2, 8'h41, 64, 128, 16'd100, 16'd200, 16'h0100, 16'h0100);
      checkOutput("A_first_addr", got_addr, 22'h048200);
      checkOutput("A_reads", reads_seen, 512);
`ifndef GLYPH_TRANSPARENT_SKIP_EN
      checkOutput("A_pixels", hs_count, 8192);
`endif
      checkOutput("A_last_count", last_count, 1);

      $display("[TB] half-width downscale");
      fixed_lat = 0;
      applyStimulus(7, 8'h30, 32, 1, 16'hFFF0, 16'h0005, 16'h0200, 16'h0100);
      checkOutput("B_reads", reads_seen, 4);

      $display("[TB] double-width upscale with stall");
      fixed_lat = -1; ready_mode = 2; stall_left = 5; gap_check = 0;
      applyStimulus(1, 8'hC3, 128, 1, 16'd0, 16'd0, 16'h0080, 16'h0100);
      checkOutput("C_reads", reads_seen, 4);
`ifndef GLYPH_TRANSPARENT_SKIP_EN
      checkOutput("C_pixels", hs_count, 128);
`endif

      $display("[TB] column clamp");
      ready_mode = 0;
      applyStimulus(31, 8'hFF, 40, 2, 16'h7FF0, 16'h8000, 16'h0400, 16'h0100);
      checkOutput("D_reads", reads_seen, 8);

      $display("[TB] empty commands");
      applyStimulus(3, 8'h20, 0, 5, 16'd0, 16'd0, 16'h0100, 16'h0100);
      applyStimulus(3, 8'h20, 5, 0, 16'd0, 16'd0, 16'h0100, 16'h0100);

      $display("[TB] reset during fetch");
      fixed_lat = 6;
      buildModel(2, 8'h41, 16, 4, 16'd0, 16'd0, 16'h0100, 16'h0100);
      sendCmd(2, 8'h41, 16, 4, 16'd0, 16'd0, 16'h0100, 16'h0100);
      for (int i = 0; i < 20 && !flash_req; i++) @(negedge clk);
      checkOutput("R_req_before", flash_req, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("R_req_async", flash_req, 1'b0);
      checkOutput("R_addr_async", flash_addr, 22'd0);
      checkOutput("R_busy_async", busy, 1'b0);
      checkOutput("R_ready_async", cmd_ready, 1'b0);
      exp_pix.delete();
      exp_addr.delete();
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("R_ready_after", cmd_ready, 1'b1);
      checkOutput("R_busy_after", busy, 1'b0);
      fixed_lat = 2;
      applyStimulus(2, 8'h41, 16, 4, 16'd0, 16'd0, 16'h0100, 16'h0100);
      checkOutput("R_refetch_addr", got_addr, 22'h048200);

      $display("[TB] random commands");
      fixed_lat = -1; ready_mode = 1; spurious_en = 1;
      for (int n = 0; n < 12; n++) begin
         w = $urandom_range(1, 40);
         h = $urandom_range(1, 8);
         applyStimulus($urandom_range(0, 31), $urandom_range(0, 255), w, h,
                       16'($urandom), 16'($urandom), $urandom_range(0, 16'h0400),
                       $urandom_range(0, 16'h1400));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
